// File: rtl/cass_player.sv
// Level II 500-baud cassette playback: leader, 0xA5 sync, then ROM bytes as clock/data pulses,
// plus the port 0xFF pulse-detect latch. Define CASS_LOOP_EN to auto-rewind after a silent cell.
module cass_player #(
    parameter int ADDR_W       = 14,
    parameter int LEN          = 16384,
    parameter int CELL         = 3500,
    parameter int PULSE_W      = 200,
    parameter int LEADER_BYTES = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              motor,
    input  logic              rewind,
    input  logic              latch_clr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              cass_pulse,
    output logic              cass_latch,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W  = 12;
    localparam int BC_MAX = (LEADER_BYTES > LEN) ? LEADER_BYTES : LEN;
    localparam int BC_W   = $clog2(BC_MAX + 1);

    localparam logic [CNT_W-1:0]  CELL_LAST   = CNT_W'(CELL - 1);
    localparam logic [CNT_W-1:0]  HALF        = CNT_W'(CELL / 2);
    localparam logic [CNT_W-1:0]  HALF_END    = CNT_W'(CELL / 2 + PULSE_W);
    localparam logic [CNT_W-1:0]  PW          = CNT_W'(PULSE_W);
    localparam logic [BC_W-1:0]   LEADER_LAST = BC_W'(LEADER_BYTES - 1);
    localparam logic [BC_W-1:0]   DATA_LAST   = BC_W'(LEN - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST   = ADDR_W'(LEN - 1);

    typedef enum logic [2:0] {IDLE, LEADER, SYNC, DATA, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cell_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic [BC_W-1:0]  byte_cnt;

    logic [CNT_W-1:0] cnt_inc;
    logic             cell_end;
    logic             last_byte;
    logic             in_window;
    logic             pulse_next;

    assign cnt_inc   = cell_cnt + 1'b1;
    assign cell_end  = (cell_cnt == CELL_LAST);
    assign last_byte = (byte_cnt == DATA_LAST);
    assign in_window = (cnt_inc < PW) || (shift[7] && (cnt_inc >= HALF) && (cnt_inc < HALF_END));

    // Pulse level for the state the next clk will hold; also drives the latch rising-edge detect.
    always_comb begin
        pulse_next = 1'b0;
        if (!rewind) begin
            case (state)
                IDLE: pulse_next = ce && motor;
                LEADER, SYNC, DATA: begin
                    if (!motor)
                        pulse_next = 1'b0;
                    else if (!ce)
                        pulse_next = cass_pulse;
                    else if (!cell_end)
                        pulse_next = in_window;
                    else
                        pulse_next = !((state == DATA) && (bit_idx == 3'd0) && last_byte);
                end
`ifdef CASS_LOOP_EN
                DONE: pulse_next = ce && cell_end && motor;
`else
                DONE: pulse_next = 1'b0;
`endif
                default: pulse_next = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rom_addr   <= '0;
            cass_pulse <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cell_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_cnt   <= '0;
        end else begin
            cass_pulse <= pulse_next;
            if (rewind) begin
                state    <= IDLE;
                rom_addr <= '0;
                busy     <= 1'b0;
                done     <= 1'b0;
                cell_cnt <= '0;
                bit_idx  <= '0;
                byte_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ce && motor) begin
                            state    <= LEADER;
                            busy     <= 1'b1;
                            shift    <= 8'h00;
                            byte_cnt <= '0;
                            cell_cnt <= '0;
                            bit_idx  <= 3'd7;
                        end
                    end
                    LEADER, SYNC, DATA: begin
                        if (motor && ce) begin
                            if (!cell_end) begin
                                cell_cnt <= cnt_inc;
                            end else if (bit_idx != 3'd0) begin
                                cell_cnt <= '0;
                                bit_idx  <= bit_idx - 3'd1;
                                shift    <= {shift[6:0], 1'b0};
                            end else begin
                                // Byte boundary: the next byte is loaded on the same ce that ends bit 0.
                                cell_cnt <= '0;
                                bit_idx  <= 3'd7;
                                case (state)
                                    LEADER: begin
                                        if (byte_cnt == LEADER_LAST) begin
                                            state    <= SYNC;
                                            shift    <= 8'hA5;
                                            byte_cnt <= '0;
                                        end else begin
                                            shift    <= 8'h00;
                                            byte_cnt <= byte_cnt + 1'b1;
                                        end
                                    end
                                    SYNC: begin
                                        state    <= DATA;
                                        shift    <= rom_data;
                                        byte_cnt <= '0;
                                        if (rom_addr != ADDR_LAST)
                                            rom_addr <= rom_addr + 1'b1;
                                    end
                                    default: begin
                                        if (last_byte) begin
                                            state <= DONE;
                                            busy  <= 1'b0;
                                            done  <= 1'b1;
                                        end else begin
                                            shift    <= rom_data;
                                            byte_cnt <= byte_cnt + 1'b1;
                                            if (rom_addr != ADDR_LAST)
                                                rom_addr <= rom_addr + 1'b1;
                                        end
                                    end
                                endcase
                            end
                        end
                    end
`ifdef CASS_LOOP_EN
                    DONE: begin
                        // One silent cell, then start over from the top of the tape.
                        if (ce) begin
                            if (!cell_end) begin
                                cell_cnt <= cnt_inc;
                            end else begin
                                cell_cnt <= '0;
                                rom_addr <= '0;
                                done     <= 1'b0;
                                if (motor) begin
                                    state    <= LEADER;
                                    busy     <= 1'b1;
                                    shift    <= 8'h00;
                                    byte_cnt <= '0;
                                    bit_idx  <= 3'd7;
                                end else begin
                                    state <= IDLE;
                                end
                            end
                        end
                    end
`else
                    DONE: done <= 1'b1;
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Set wins over clear so a pulse arriving with OUT 0xFF is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cass_latch <= 1'b0;
        else if (pulse_next && !cass_pulse)
            cass_latch <= 1'b1;
        else if (latch_clr)
            cass_latch <= 1'b0;
    end
endmodule
